// File: rtl/rx_char_decoder.sv
// IEEE-1355 DS-SE character decoder: frames bit pairs into data/control characters.
// Optional build macro RX_DISCONNECT_EN adds the idle-timeout disconnect detector.
module rx_char_decoder #(
   parameter int DISC_CYCLES = 512
) (
   input  logic       rxClk,
   input  logic       rxReset,
   input  logic [1:0] dq,
   input  logic       dqValid,
   output logic [7:0] rxData,
   output logic       rxCtl,
   output logic       rxStrobe,
   output logic       rxFcc,
   output logic       rxNull,
   output logic       rxSynced,
   output logic       rxParityErr,
   output logic       rxEscErr,
   output logic       rxDisconnect,
   output logic       rxError
);

   typedef enum logic [1:0] {HDR, DATA, CTL} state_t;

   state_t     state;
   logic [1:0] cnt;
   logic       acc;
   logic       esc_pend;
   logic [5:0] shift;
   logic       timeout;
   logic       deliver;

   assign deliver = rxSynced && !rxError;

`ifdef RX_DISCONNECT_EN
   localparam int CW = $clog2(DISC_CYCLES + 1);
   localparam logic [CW-1:0] LIMIT = CW'(DISC_CYCLES);

   logic [CW-1:0] idle;

   always_ff @(posedge rxClk) begin
      if (rxReset) begin
         idle         <= '0;
         rxDisconnect <= 1'b0;
      end else begin
         if (dqValid)
            idle <= '0;
         else if (idle != LIMIT)
            idle <= idle + 1'b1;
         if (timeout)
            rxDisconnect <= 1'b1;
      end
   end

   assign timeout = rxSynced && (idle == LIMIT);
`else
   assign rxDisconnect = 1'b0;
   assign timeout      = 1'b0;
`endif

   always_ff @(posedge rxClk) begin
      if (rxReset) begin
         state       <= HDR;
         cnt         <= 2'd0;
         acc         <= 1'b0;
         esc_pend    <= 1'b0;
         shift       <= 6'd0;
         rxData      <= 8'd0;
         rxCtl       <= 1'b0;
         rxStrobe    <= 1'b0;
         rxFcc       <= 1'b0;
         rxNull      <= 1'b0;
         rxSynced    <= 1'b0;
         rxParityErr <= 1'b0;
         rxEscErr    <= 1'b0;
         rxError     <= 1'b0;
      end else begin
         rxStrobe    <= 1'b0;
         rxFcc       <= 1'b0;
         rxNull      <= 1'b0;
         rxParityErr <= 1'b0;
         rxEscErr    <= 1'b0;
         if (timeout)
            rxError <= 1'b1;
         if (dqValid) begin
            unique case (state)
               HDR: begin
                  // parity covers previous character body plus this P and F
                  if (!(acc ^ dq[0] ^ dq[1])) begin
                     rxParityErr <= 1'b1;
                     rxError     <= 1'b1;
                  end
                  acc   <= 1'b0;
                  cnt   <= 2'd0;
                  state <= dq[1] ? CTL : DATA;
               end
               DATA: begin
                  acc <= acc ^ dq[0] ^ dq[1];
                  cnt <= cnt + 2'd1;
                  if (cnt == 2'd0) shift[1:0] <= dq;
                  if (cnt == 2'd1) shift[3:2] <= dq;
                  if (cnt == 2'd2) shift[5:4] <= dq;
                  if (cnt == 2'd3) begin
                     state <= HDR;
                     if (esc_pend) begin
                        esc_pend <= 1'b0;
                        rxEscErr <= 1'b1;
                        rxError  <= 1'b1;
                     end else if (deliver) begin
                        rxStrobe <= 1'b1;
                        rxCtl    <= 1'b0;
                        rxData   <= {dq, shift};
                     end
                  end
               end
               CTL: begin
                  acc   <= acc ^ dq[0] ^ dq[1];
                  state <= HDR;
                  if (esc_pend) begin
                     esc_pend <= 1'b0;
                     if (dq == 2'b00) begin
                        rxSynced <= 1'b1;
                        if (!rxError) rxNull <= 1'b1;
                     end else begin
                        rxEscErr <= 1'b1;
                        rxError  <= 1'b1;
                     end
                  end else if (dq == 2'b11) begin
                     esc_pend <= 1'b1;
                  end else if (dq == 2'b00) begin
                     if (deliver) rxFcc <= 1'b1;
                  end else if (deliver) begin
                     rxStrobe <= 1'b1;
                     rxCtl    <= 1'b1;
                     rxData   <= {6'd0, dq};
                  end
               end
               default: state <= HDR;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rx_char_decoder.sv
// Directed self-checking bench for rx_char_decoder.
// Build with RX_DISCONNECT_EN to also exercise the idle-timeout path.
module tb_rx_char_decoder;

   logic       rxClk = 1'b0;
   logic       rxReset = 1'b1;
   logic [1:0] dq = 2'b00;
   logic       dqValid = 1'b0;
   logic [7:0] rxData;
   logic       rxCtl, rxStrobe, rxFcc, rxNull, rxSynced;
   logic       rxParityErr, rxEscErr, rxDisconnect, rxError;

   always #5 rxClk = ~rxClk;

   rx_char_decoder #(.DISC_CYCLES(16)) dut (
      .rxClk(rxClk), .rxReset(rxReset), .dq(dq), .dqValid(dqValid),
      .rxData(rxData), .rxCtl(rxCtl), .rxStrobe(rxStrobe),
      .rxFcc(rxFcc), .rxNull(rxNull), .rxSynced(rxSynced),
      .rxParityErr(rxParityErr), .rxEscErr(rxEscErr),
      .rxDisconnect(rxDisconnect), .rxError(rxError)
   );

   int tests = 0;
   int fails = 0;

   logic clr = 1'b1;
   int n_strobe, n_fcc, n_null, n_perr, n_eerr;

   always @(negedge rxClk) begin
      if (clr) begin
         n_strobe = 0; n_fcc = 0; n_null = 0; n_perr = 0; n_eerr = 0;
      end else begin
         if (rxStrobe)    n_strobe++;
         if (rxFcc)       n_fcc++;
         if (rxNull)      n_null++;
         if (rxParityErr) n_perr++;
         if (rxEscErr)    n_eerr++;
      end
   end

   logic [16:0] all_out;
   assign all_out = {rxData, rxCtl, rxStrobe, rxFcc, rxNull, rxSynced,
                     rxParityErr, rxEscErr, rxDisconnect, rxError};

   logic       acc_m = 1'b0;
   logic       s_strobe, s_fcc, s_null, s_perr, s_eerr, s_ctl, h_perr;
   logic [7:0] s_data;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge rxClk);
      rxReset = 1'b1; clr = 1'b1; dqValid = 1'b0;
      repeat (2) @(negedge rxClk);
      rxReset = 1'b0; clr = 1'b0; acc_m = 1'b0;
   endtask

   // one pair, then two idle cycles; snapshot taken one cycle after dqValid
   task automatic pair(input logic d0, input logic d1);
      @(negedge rxClk);
      dq = {d1, d0}; dqValid = 1'b1;
      @(negedge rxClk);
      dqValid = 1'b0;
      s_strobe = rxStrobe; s_fcc = rxFcc; s_null = rxNull;
      s_perr = rxParityErr; s_eerr = rxEscErr;
      s_data = rxData; s_ctl = rxCtl;
      @(negedge rxClk);
   endtask

   task automatic hdr(input logic f, input logic flip);
      logic p;
      p = ~(acc_m ^ f) ^ flip;
      pair(p, f);
      h_perr = s_perr;
      acc_m = 1'b0;
   endtask

   task automatic send_data(input logic [7:0] b, input logic flip);
      hdr(1'b0, flip);
      for (int k = 0; k < 4; k++) begin
         pair(b[2*k], b[2*k+1]);
         acc_m = acc_m ^ b[2*k] ^ b[2*k+1];
      end
   endtask

   task automatic send_ctl(input logic [1:0] c, input logic flip);
      hdr(1'b1, flip);
      pair(c[0], c[1]);
      acc_m = acc_m ^ c[0] ^ c[1];
   endtask

   task automatic send_null();
      send_ctl(2'b11, 1'b0);
      send_ctl(2'b00, 1'b0);
   endtask

   initial begin
      repeat (3) @(negedge rxClk);
      chk("reset_outputs", 32'(all_out), 32'd0);
      rxReset = 1'b0; clr = 1'b0;

      // NULL sync
      send_ctl(2'b11, 1'b0);
      chk("esc_no_sync", 32'(rxSynced), 32'd0);
      send_ctl(2'b00, 1'b0);
      chk("null_pulse", 32'(s_null), 32'd1);
      chk("synced", 32'(rxSynced), 32'd1);
      send_null();
      chk("null_count", 32'(n_null), 32'd2);
      chk("null_no_err", 32'({rxError, 8'(n_perr + n_eerr)}), 32'd0);

      // data byte
      do_reset();
      send_null();
      send_data(8'hA5, 1'b0);
      chk("data_strobe", 32'(s_strobe), 32'd1);
      chk("data_value", 32'(s_data), 32'hA5);
      chk("data_ctl", 32'(s_ctl), 32'd0);
      chk("data_count", 32'(n_strobe), 32'd1);
      send_ctl(2'b00, 1'b0);
      chk("data_hold", 32'(rxData), 32'hA5);
      chk("fcc_after_data", 32'(n_fcc), 32'd1);

      // FCC then EOP-2
      do_reset();
      send_null();
      send_ctl(2'b00, 1'b0);
      chk("fcc_pulse", 32'(s_fcc), 32'd1);
      send_ctl(2'b10, 1'b0);
      chk("eop2_strobe", 32'(s_strobe), 32'd1);
      chk("eop2_data", 32'(s_data), 32'h02);
      chk("eop2_ctl", 32'(s_ctl), 32'd1);
      chk("eop_fcc_count", 32'(n_fcc), 32'd1);

      // parity error
      do_reset();
      send_null();
      send_data(8'h01, 1'b0);
      chk("par_data_ok", 32'(n_strobe), 32'd1);
      send_ctl(2'b00, 1'b1);
      chk("par_pulse", 32'(h_perr), 32'd1);
      chk("par_error", 32'(rxError), 32'd1);
      send_data(8'h33, 1'b0);
      chk("par_suppress", 32'(n_strobe), 32'd1);
      chk("par_fcc_suppress", 32'(n_fcc), 32'd0);
      chk("par_count", 32'(n_perr), 32'd1);

      // pre-sync data and escape error
      do_reset();
      send_data(8'h55, 1'b0);
      chk("presync_suppress", 32'(n_strobe), 32'd0);
      chk("presync_no_perr", 32'(n_perr), 32'd0);
      send_null();
      send_ctl(2'b11, 1'b0);
      send_ctl(2'b01, 1'b0);
      chk("esc_err_pulse", 32'(s_eerr), 32'd1);
      chk("esc_err_sticky", 32'(rxError), 32'd1);
      chk("esc_no_strobe", 32'(n_strobe), 32'd0);

      // reset in the middle of a data character
      do_reset();
      send_null();
      hdr(1'b0, 1'b0);
      pair(1'b1, 1'b0);
      pair(1'b0, 1'b1);
      @(negedge rxClk);
      rxReset = 1'b1; clr = 1'b1;
      repeat (2) @(negedge rxClk);
      chk("midchar_reset", 32'(all_out), 32'd0);
      rxReset = 1'b0; clr = 1'b0; acc_m = 1'b0;
      repeat (3) @(negedge rxClk);
      chk("midchar_no_pulse", 32'(n_strobe + n_fcc + n_null), 32'd0);
      send_null();
      send_data(8'h3C, 1'b0);
      chk("after_reset_data", 32'(s_data), 32'h3C);
      chk("after_reset_ok", 32'({rxError, 8'(n_perr + n_eerr)}), 32'd0);

`ifdef RX_DISCONNECT_EN
      do_reset();
      repeat (40) @(negedge rxClk);
      chk("disc_presync", 32'(rxDisconnect), 32'd0);
      send_null();
      repeat (10) @(negedge rxClk);
      chk("disc_early", 32'(rxDisconnect), 32'd0);
      repeat (10) @(negedge rxClk);
      chk("disc_set", 32'(rxDisconnect), 32'd1);
      chk("disc_error", 32'(rxError), 32'd1);
`else
      do_reset();
      send_null();
      repeat (50) @(negedge rxClk);
      chk("disc_tied_low", 32'({rxDisconnect, rxError}), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
